// File: rtl/down_timer12.sv
`default_nettype none
// ============================================================================
//  Module      : down_timer12
//  Description : Loadable down-counting timer with a one-cycle terminal-count
//                pulse, busy status and optional auto-reload from the last
//                loaded value.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK   in   1      rising-edge clock
//    reset in   1      asynchronous active-high reset, clears all state
//    En    in   1      count enable (decrement only while high)
//    LA    in   1      synchronous load strobe, priority over En
//    load  in   WIDTH  value captured into count and reload register on LA
//    auto  in   1      1 = reload on expiry, 0 = one-shot
//    Out   out  WIDTH  current count (registered)
//    tc    out  1      terminal-count pulse, one cycle per expiry (registered)
//    busy  out  1      high while running (registered)
//    zero  out  1      Out == 0 (combinational from Out only)
// ============================================================================
module down_timer12 #(
   parameter int WIDTH = 12
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             En,
   input  logic             LA,
   input  logic [WIDTH-1:0] load,
   input  logic             auto,
   output logic [WIDTH-1:0] Out,
   output logic             tc,
   output logic             busy,
   output logic             zero
);

   localparam logic [0:0]       S_IDLE = 1'b0;
   localparam logic [0:0]       S_RUN  = 1'b1;
   localparam logic [WIDTH-1:0] c_ZERO = '0;
   localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_rld;
   logic             r_tc;

   logic [0:0]       w_state_nxt;
   logic [WIDTH-1:0] w_cnt_nxt;
   logic [WIDTH-1:0] w_rld_nxt;
   logic             w_tc_nxt;

   // State register: FSM state together with the registered datapath.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= c_ZERO;
         r_rld   <= c_ZERO;
         r_tc    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rld   <= w_rld_nxt;
         r_tc    <= w_tc_nxt;
      end
   end

   // Next-state logic. tc defaults low so it can only ever last one cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rld_nxt   = r_rld;
      w_tc_nxt    = 1'b0;

      if (LA) begin
         // A load always wins, even on the expiry edge, and suppresses tc.
         w_cnt_nxt   = load;
         w_rld_nxt   = load;
         w_state_nxt = (load != c_ZERO) ? S_RUN : S_IDLE;
      end else if ((r_state == S_RUN) && En) begin
         if (r_cnt == c_ONE) begin
            // Expiry replaces the decrement from 1, so the count never
            // underflows. In RUN the reload value is always non-zero.
            w_tc_nxt = 1'b1;
            if (auto) begin
               w_cnt_nxt = r_rld;
            end else begin
               w_cnt_nxt   = c_ZERO;
               w_state_nxt = S_IDLE;
            end
         end else begin
            w_cnt_nxt = r_cnt - c_ONE;
         end
      end
   end

   // Output logic: all outputs come straight from registers except zero.
   always_comb begin
      Out  = r_cnt;
      tc   = r_tc;
      busy = (r_state == S_RUN);
      zero = (r_cnt == c_ZERO);
   end

endmodule
`default_nettype wire

// File: tb/tb_down_timer12.sv
`default_nettype none
// ============================================================================
//  Module      : tb_down_timer12
//  Description : Self-checking bench for down_timer12. A behavioural model is
//                compared against the DUT every cycle; directed scenarios add
//                hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_down_timer12;

   logic        CLK;
   logic        reset;
   logic        En;
   logic        LA;
   logic [11:0] load;
   logic        auto;
   logic [11:0] Out;
   logic        tc;
   logic        busy;
   logic        zero;

   int n_checks = 0;
   int n_pass   = 0;

   down_timer12 #(.WIDTH(12)) dut (
      .CLK   (CLK),
      .reset (reset),
      .En    (En),
      .LA    (LA),
      .load  (load),
      .auto  (auto),
      .Out   (Out),
      .tc    (tc),
      .busy  (busy),
      .zero  (zero)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: an integer count, the remembered load value and a
   // running flag, updated by the timer's rules once per edge.
   int m_cnt  = 0;
   int m_rld  = 0;
   int m_tc   = 0;
   int m_busy = 0;

   always @(posedge CLK or posedge reset) begin
      if (reset) begin
         m_cnt  <= 0;
         m_rld  <= 0;
         m_tc   <= 0;
         m_busy <= 0;
      end else if (LA) begin
         m_cnt  <= int'(load);
         m_rld  <= int'(load);
         m_tc   <= 0;
         m_busy <= (load != 0) ? 1 : 0;
      end else if (m_busy == 1 && En) begin
         if (m_cnt == 1) begin
            m_tc   <= 1;
            m_cnt  <= auto ? m_rld : 0;
            m_busy <= auto ? 1 : 0;
         end else begin
            m_cnt  <= m_cnt - 1;
            m_tc   <= 0;
         end
      end else begin
         m_tc <= 0;
      end
   end

   // Per-cycle comparison, away from the active edge.
   always @(negedge CLK) begin
      chk("model_Out",  int'(Out),  m_cnt);
      chk("model_tc",   int'(tc),   m_tc);
      chk("model_busy", int'(busy), m_busy);
      chk("model_zero", int'(zero), (m_cnt == 0) ? 1 : 0);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   int exp_out [7] = '{2, 1, 3, 3, 2, 1, 3};
   int exp_tc  [7] = '{0, 0, 1, 0, 0, 0, 1};
   int en_seq  [7] = '{1, 1, 1, 0, 1, 1, 1};
   int n_wait;
   bit found;

   initial begin
      reset = 1'b1; En = 1'b0; LA = 1'b0; load = 12'd0; auto = 1'b0;
      tick(); tick();
      chk("rst_Out",  int'(Out),  0);
      chk("rst_tc",   int'(tc),   0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_zero", int'(zero), 1);
      reset = 1'b0;

      // Reset mid-count takes effect without a clock edge.
      LA = 1'b1; load = 12'd10; En = 1'b1;
      tick();
      LA = 1'b0;
      tick(); tick(); tick();
      chk("mid_Out_before", int'(Out), 7);
      #3 reset = 1'b1;
      #1;
      chk("arst_Out",  int'(Out),  0);
      chk("arst_tc",   int'(tc),   0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_zero", int'(zero), 1);
      #2 reset = 1'b0;
      tick(); tick();
      chk("post_rst_Out", int'(Out), 0);

      // One-shot count from 5.
      auto = 1'b0; LA = 1'b1; load = 12'd5; En = 1'b1;
      tick();
      chk("os_load_Out",  int'(Out),  5);
      chk("os_load_busy", int'(busy), 1);
      LA = 1'b0;
      for (int k = 4; k >= 1; k--) begin
         tick();
         chk("os_Out", int'(Out), k);
         chk("os_tc",  int'(tc),  0);
      end
      tick();
      chk("os_end_Out",  int'(Out),  0);
      chk("os_end_tc",   int'(tc),   1);
      chk("os_end_busy", int'(busy), 0);
      chk("os_end_zero", int'(zero), 1);
      tick();
      chk("os_after_Out", int'(Out), 0);
      chk("os_after_tc",  int'(tc),  0);

      // Auto-reload of 3 with one paused cycle in the second period.
      auto = 1'b1; LA = 1'b1; load = 12'd3; En = 1'b1;
      tick();
      chk("ar_load_Out", int'(Out), 3);
      LA = 1'b0;
      for (int i = 0; i < 7; i++) begin
         En = en_seq[i][0];
         tick();
         chk("ar_Out", int'(Out), exp_out[i]);
         chk("ar_tc",  int'(tc),  exp_tc[i]);
      end
      En = 1'b0;
      tick();

      // Load of zero: stays idle, no tc.
      LA = 1'b1; load = 12'd0; En = 1'b1;
      tick();
      chk("l0_busy", int'(busy), 0);
      chk("l0_zero", int'(zero), 1);
      chk("l0_tc",   int'(tc),   0);
      LA = 1'b0;
      tick();
      chk("l0_run_tc",  int'(tc),  0);
      chk("l0_run_Out", int'(Out), 0);

      // Load of one with auto: tc on every enabled cycle, Out stays 1.
      auto = 1'b1; LA = 1'b1; load = 12'd1; En = 1'b1;
      tick();
      chk("l1_tc_load", int'(tc), 0);
      LA = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("l1_tc",  int'(tc),  1);
         chk("l1_Out", int'(Out), 1);
      end
      En = 1'b0;
      tick();
      chk("l1_pause_tc", int'(tc), 0);
      En = 1'b1;
      tick();
      chk("l1_resume_tc", int'(tc), 1);

      // Load collides with the expiry edge.
      auto = 1'b0; LA = 1'b1; load = 12'd2; En = 1'b1;
      tick();
      LA = 1'b0;
      tick();
      chk("col_pre_Out", int'(Out), 1);
      LA = 1'b1; load = 12'd7;
      tick();
      chk("col_tc",   int'(tc),   0);
      chk("col_Out",  int'(Out),  7);
      chk("col_busy", int'(busy), 1);
      LA = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("col_wait_tc", int'(tc), 0);
      end
      tick();
      chk("col_exp_tc",  int'(tc),  1);
      chk("col_exp_Out", int'(Out), 0);

      // Maximum load: tc exactly 4095 cycles later, no wrap afterwards.
      auto = 1'b0; LA = 1'b1; load = 12'd4095; En = 1'b1;
      tick();
      LA = 1'b0;
      found = 1'b0;
      n_wait = 0;
      for (int n = 1; n <= 5000; n++) begin
         tick();
         if (tc) begin
            n_wait = n;
            found  = 1'b1;
            break;
         end
      end
      chk("max_tc_found", int'(found), 1);
      chk("max_tc_delay", n_wait, 4095);
      tick(); tick();
      chk("max_after_Out",  int'(Out),  0);
      chk("max_after_busy", int'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/down_timer12.md
# down_timer12

Loadable 12-bit down-counting timer with a terminal-count pulse and optional auto-reload. It complements the up-counting address counter: software or control logic loads a count, and the block counts down to zero under an enable. It signals expiry to the sequencing logic with a one-cycle `tc` pulse and a `busy` status. Sits beside the counter in the control path to generate delays, wait states and periodic ticks.

## Interface
- `WIDTH`, 12, counter and load width in bits

- `CLK`  in  1  clock, rising-edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `En`  in  1  count enable; decrement only when high
- `LA`  in  1  synchronous load strobe; priority over `En`
- `load`  in  WIDTH  count value captured on `LA`
- `auto`  in  1  1 = reload `Out` from the stored reload value on expiry; 0 = one-shot
- `Out`  out  WIDTH  current count (registered)
- `tc`  out  1  terminal-count pulse, high for exactly one cycle per expiry (registered)
- `busy`  out  1  high while in RUN (registered)
- `zero`  out  1  combinational `Out == 0`

## Operation
- Internal reload register `rld` (WIDTH bits) holds the last loaded value.
- FSM states: IDLE, RUN.
- Reset (async, any time, including mid-count): `Out`=0, `rld`=0, `tc`=0, `busy`=0, state IDLE. `zero`=1.
- Priority at each rising edge: `reset` > `LA` > `En` > hold.
- `LA`=1, any state: `Out`<=`load`, `rld`<=`load`, `tc`<=0.
  - If `load`!=0, go to RUN (`busy`<=1).
  - If `load`==0, go to IDLE (`busy`<=0). No `tc` is produced.
- IDLE, no `LA`: `Out` holds and `En` is ignored. IDLE never decrements and never wraps below 0.
- RUN, `LA`=0, `En`=1:
  - `Out`>1: `Out`<=`Out`-1, `tc`<=0.
  - `Out`==1, `auto`=0: `Out`<=0, `tc`<=1, go to IDLE (`busy`<=0).
  - `Out`==1, `auto`=1: `Out`<=`rld`, `tc`<=1, stay in RUN. `Out` never shows 0 in auto mode.
- RUN, `LA`=0, `En`=0: `Out` holds, `tc`<=0 (pause; the count resumes when `En` returns).
- `auto` is sampled at the expiry edge only. Changing it mid-count affects only the next expiry.
- Arithmetic is unsigned modulo 2^WIDTH. There is no underflow path, because the decrement from 1 is always replaced by the expiry action.
- `LA` coinciding with the expiry edge: the load wins and `tc` stays 0 for that edge.

## Timing
- Load of N (N>0) at edge 0, `En` held high: `Out`=N after edge 0, N-k after edge k, and `tc`=1 after edge N, for one cycle.
- One-shot: after edge N, `Out`=0, `busy`=0, `zero`=1.
- Auto: `tc` pulses every N enabled cycles. Period = N cycles with `En` held high. `Out` sequence: N, N-1, …, 1, N, …
- Each cycle with `En` low stretches the period by exactly one cycle.
- `tc` and `busy` are registered: no combinational path from any input to `tc`, `busy` or `Out`. `zero` depends only on `Out`.
- Max load 4095: `tc` 4095 cycles after the load.

## Test plan
- Reset mid-count: load 10, run 3 cycles, assert `reset` between edges -> `Out`=0, `tc`=0, `busy`=0 immediately, without waiting for `CLK`. After release, `En`=1 leaves `Out`=0.
- One-shot: load 5, `auto`=0, `En`=1 -> `Out` 5,4,3,2,1,0; `tc`=1 only in the cycle `Out` first reads 0; `busy` falls on the same edge; `Out` stays 0 afterwards.
- Auto-reload with pause: load 3, `auto`=1, `En` low for 1 cycle in the second period -> `tc` pulses at cycles 3 and 7; `Out` sequence 3,2,1,3,3,2,1,3.
- Load edge cases: load 0 -> `busy`=0, `zero`=1, no `tc`. Load 1 with `auto`=1 -> `tc` high every enabled cycle as separate single-cycle pulses, `Out` stays 1.
- Collision: load 2, then `LA`=1 with `load`=7 on the edge where `Out`==1 -> `tc` stays 0, `Out`=7, `busy`=1, and the next `tc` arrives 7 cycles later.
- Max value: load 4095, `auto`=0 -> `tc` exactly 4095 cycles after the load, no wrap to 4095 afterwards.
